// File: rtl/mod_n_updown_counter.sv
// Mod-N up/down counter with terminal-count, wrap and illegal-load indications.
// The state bank is updated per bit through JK excitation with J=K=toggle.
module mod_n_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10,
  parameter int unsigned INIT    = 0
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             sync_clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT);
  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   ModVal  = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d, target, toggle;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             at_max, at_zero, out_of_range, load_ok;

  assign at_max       = (count_q == MaxVal);
  assign at_zero      = (count_q == '0);
  assign out_of_range = ({1'b0, count_q} >= ModVal);
  assign load_ok      = ({1'b0, load_val} < ModVal);

  always_comb begin
    target = count_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (sync_clear) begin
      target = InitVal;
    end else if (load) begin
      if (load_ok) begin
        target = load_val;
      end else begin
        target = '0;
        err_d  = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_max || out_of_range) begin
          target = '0;
          wrap_d = 1'b1;
        end else begin
          target = count_q + WIDTH'(1);
        end
      end else begin
        if (out_of_range) begin
          target = '0;
        end else if (at_zero) begin
          target = MaxVal;
          wrap_d = 1'b1;
        end else begin
          target = count_q - WIDTH'(1);
        end
      end
    end
  end

  // JK excitation: Q+ = J&~Q | ~K&Q with J=K=toggle.
  always_comb begin
    toggle  = count_q ^ target;
    count_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_d[i] = (toggle[i] & ~count_q[i]) | (~toggle[i] & count_q[i]);
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      count_q <= InitVal;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;
  assign tc       = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter: a mod-10 and a mod-16 instance share
// stimulus; expected results are queued at drive time and popped after the edge.
module tb_mod_n_updown_counter;

  typedef struct packed {
    logic [3:0] c;
    logic       w;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       async_reset_n;
  logic       sync_clear, en, up, load;
  logic [3:0] load_val;
  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, wrap_a, wrap_b, err_a, err_b;

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [3:0] ma, mb;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_dut10 (
    .clk(clk), .async_reset_n(async_reset_n), .sync_clear(sync_clear), .en(en),
    .up(up), .load(load), .load_val(load_val), .count(count_a), .tc(tc_a),
    .wrap(wrap_a), .load_err(err_a)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .INIT(0)) u_dut16 (
    .clk(clk), .async_reset_n(async_reset_n), .sync_clear(sync_clear), .en(en),
    .up(up), .load(load), .load_val(load_val), .count(count_b), .tc(tc_b),
    .wrap(wrap_b), .load_err(err_b)
  );

  function automatic exp_t model(int m, logic [3:0] c, logic clr, logic ld,
                                 logic [3:0] lv, logic e, logic u);
    exp_t r;
    r = '{c: c, w: 1'b0, e: 1'b0};
    if (clr) begin
      r.c = 4'd0;
    end else if (ld) begin
      if (int'(lv) < m) r.c = lv;
      else begin
        r.c = 4'd0;
        r.e = 1'b1;
      end
    end else if (e) begin
      if (u) begin
        if (int'(c) >= m - 1) begin
          r.c = 4'd0;
          r.w = 1'b1;
        end else r.c = c + 4'd1;
      end else begin
        if (int'(c) >= m) r.c = 4'd0;
        else if (c == 4'd0) begin
          r.c = 4'(m - 1);
          r.w = 1'b1;
        end else r.c = c - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic model_tc(int m, logic [3:0] c, logic e, logic u);
    return e & ((u & (int'(c) == m - 1)) | (~u & (c == 4'd0)));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic clr, input logic ld, input logic [3:0] lv,
                       input logic e, input logic u);
    exp_t ea, eb;
    sync_clear = clr;
    load       = ld;
    load_val   = lv;
    en         = e;
    up         = u;
    #1;
    check("tc_m10", 8'(tc_a), 8'(model_tc(10, ma, e, u)));
    check("tc_m16", 8'(tc_b), 8'(model_tc(16, mb, e, u)));
    q_a.push_back(model(10, ma, clr, ld, lv, e, u));
    q_b.push_back(model(16, mb, clr, ld, lv, e, u));
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    ma = ea.c;
    mb = eb.c;
    check("count_m10", 8'(count_a), 8'(ea.c));
    check("wrap_m10", 8'(wrap_a), 8'(ea.w));
    check("err_m10", 8'(err_a), 8'(ea.e));
    check("count_m16", 8'(count_b), 8'(eb.c));
    check("wrap_m16", 8'(wrap_b), 8'(eb.w));
    check("err_m16", 8'(err_b), 8'(eb.e));
    @(negedge clk);
  endtask

  task automatic reset_mid;
    #2;
    async_reset_n = 1'b0;
    #1;
    ma = 4'd0;
    mb = 4'd0;
    check("rst_count_m10", 8'(count_a), 8'd0);
    check("rst_wrap_m10", 8'(wrap_a), 8'd0);
    check("rst_count_m16", 8'(count_b), 8'd0);
    check("rst_err_m16", 8'(err_b), 8'd0);
    @(negedge clk);
    async_reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    async_reset_n = 1'b0;
    sync_clear = 1'b0;
    en = 1'b0;
    up = 1'b1;
    load = 1'b0;
    load_val = 4'd0;
    ma = 4'd0;
    mb = 4'd0;
    @(negedge clk);
    #1;
    check("por_count_m10", 8'(count_a), 8'd0);
    check("por_wrap_m10", 8'(wrap_a), 8'd0);
    check("por_err_m10", 8'(err_a), 8'd0);
    @(negedge clk);
    async_reset_n = 1'b1;

    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    // Up through the mod-10 wrap
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    // Down through zero
    cycle(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    // Legal load, illegal load (mod 10), pulse must drop next cycle
    cycle(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    // Load beats enable; clear beats both
    cycle(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
    // Hold
    cycle(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    // Full-range edge on the mod-16 instance, both directions
    cycle(1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    // Async reset mid-count
    cycle(1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
    reset_mid();
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
